// File: rtl/instr_sequencer_if.sv
// Signal bundle between the instruction sequencer and its neighbours
// (instruction memory, ALU branch unit, data memory, register file).
interface instr_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  // Handshakes: instr is taken only in a cycle where imem_valid=1 while fetching;
  // dmem_req (with dmem_we) holds steady until a cycle with dmem_ready=1 completes it.
  logic             start;
  logic [8:0]       instr;
  logic             imem_valid;
  logic             dmem_ready;
  logic             br_taken;
  logic [PC_W-1:0]  br_target;
  logic [PC_W-1:0]  pc;
  logic [8:0]       ir;
  logic             ir_load;
  logic             alu_en;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_we;
  logic             done;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
    output start, instr, imem_valid, dmem_ready, br_taken, br_target,
    input  pc, ir, ir_load, alu_en, dmem_req, dmem_we, reg_we, done, retired, state
  );

  modport slave (
    input  start, instr, imem_valid, dmem_ready, br_taken, br_target,
    output pc, ir, ir_load, alu_en, dmem_req, dmem_we, reg_we, done, retired, state
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit core: owns PC, IR and
// the retired-instruction counter, and decodes per-cycle enables from the current state.
module instr_sequencer #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [8:0]      HALT_INSN = 9'h1FF,
  parameter int              CNT_W     = 16
) (
  input logic          clk,
  input logic          rst_n,
  instr_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0]       T_M     = 2'b01;
  localparam logic [1:0]       T_B     = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [8:0]       ir_q;
  logic [CNT_W-1:0] retired_q;
  logic             ir_load, alu_en, dmem_req, reg_we, done;
  logic             pc_load, retire, restart;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q + 1'b1;
    pc_load  = 1'b0;
    retire   = 1'b0;
    restart  = 1'b0;
    ir_load  = 1'b0;
    alu_en   = 1'b0;
    dmem_req = 1'b0;
    reg_we   = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_valid) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (ir_q == HALT_INSN) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        case (ir_q[8:7])
          T_M: state_d = S_MEM;
          T_B: begin
            // Branches finish here: no memory or writeback phase.
            state_d = S_FETCH;
            pc_load = 1'b1;
            retire  = 1'b1;
            if (bus.br_taken) pc_d = bus.br_target;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          if (ir_q[6]) begin
            state_d = S_FETCH;
            pc_load = 1'b1;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_load = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          pc_load = 1'b1;
          restart = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_load) pc_q <= pc_d;
      if (ir_load) ir_q <= bus.instr;
      if (restart) begin
        retired_q <= '0;
      end else if (retire && (retired_q != CNT_MAX)) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_load  = ir_load;
  assign bus.alu_en   = alu_en;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_req & ir_q[6];
  assign bus.reg_we   = reg_we;
  assign bus.done     = done;
  assign bus.retired  = retired_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed instruction table, randomized instruction stream
// against a per-instruction reference model, then halt/restart and reset-in-MEM sequences.
module tb_instr_sequencer;
  localparam int PC_W    = 10;
  localparam int CNT_W   = 4;
  localparam int RET_MAX = (1 << CNT_W) - 1;
  localparam int N_RAND  = 150;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [PC_W-1:0] m_pc;
  int              m_ret;

  typedef struct {
    logic [8:0]      instr;
    int              idly;
    int              ddly;
    logic            bt;
    logic [PC_W-1:0] tgt;
    int              lat;
    int              rw;
    int              dm;
    logic [PC_W-1:0] pc;
    int              ret;
  } vec_t;

  vec_t tbl [10];

  instr_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  instr_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus.ir_load, bus.alu_en, bus.dmem_req, bus.reg_we};
  endfunction

  // Reference model: cycles from start of fetch to retirement, from the phase list.
  function automatic int model_lat(input logic [8:0] i, input int idly, input int ddly);
    case (i[8:7])
      2'b01:   return idly + 1 + 1 + 1 + (ddly + 1) + (i[6] ? 0 : 1);
      2'b10:   return idly + 1 + 1 + 1;
      default: return idly + 1 + 1 + 1 + 1;
    endcase
  endfunction

  // Drives one instruction from the first FETCH cycle to retirement, then checks results.
  task automatic run_insn(input string tag, input logic [8:0] in_instr, input int idly,
                          input int ddly, input logic bt, input logic [PC_W-1:0] tgt,
                          input int e_lat, input int e_rw, input int e_dm,
                          input logic [PC_W-1:0] e_pc, input int e_ret);
    int   n_ld, ld_at, n_alu, alu_at, n_dm, n_rw, rw_at, bad_we, n_done;
    logic is_mem;
    n_ld = 0; ld_at = -1; n_alu = 0; alu_at = -1; n_dm = 0;
    n_rw = 0; rw_at = -1; bad_we = 0; n_done = 0;
    is_mem = (in_instr[8:7] == 2'b01);
    for (int c = 0; c < e_lat; c++) begin
      @(negedge clk);
      bus.start      = 1'($urandom_range(0, 1));
      bus.imem_valid = (c == idly) ? 1'b1 : ((c < idly) ? 1'b0 : 1'($urandom_range(0, 1)));
      bus.instr      = (c == idly) ? in_instr : 9'($urandom_range(0, 511));
      bus.br_taken   = (c == idly + 2) ? bt : 1'($urandom_range(0, 1));
      bus.br_target  = (c == idly + 2) ? tgt : PC_W'($urandom_range(0, 1023));
      if (is_mem && c >= idly + 3) bus.dmem_ready = (c == idly + 3 + ddly);
      else                         bus.dmem_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.ir_load)  begin n_ld++;  ld_at = c;  end
      if (bus.alu_en)   begin n_alu++; alu_at = c; end
      if (bus.dmem_req) begin
        n_dm++;
        if (bus.dmem_we !== in_instr[6]) bad_we++;
      end
      if (bus.reg_we)   begin n_rw++;  rw_at = c;  end
      if (bus.done) n_done++;
    end
    @(posedge clk);
    #1;
    check({tag, " ir_load_at"}, (n_ld == 1) ? ld_at : -1, idly);
    check({tag, " alu_en_at"}, (n_alu == 1) ? alu_at : -1, idly + 2);
    check({tag, " dmem_req_cycles"}, n_dm, e_dm);
    check({tag, " dmem_we_wrong"}, bad_we, 0);
    check({tag, " reg_we_cycles"}, n_rw, e_rw);
    if (e_rw != 0) check({tag, " reg_we_at"}, rw_at, e_lat - 1);
    check({tag, " done_cycles"}, n_done, 0);
    check({tag, " ir"}, 32'(bus.ir), 32'(in_instr));
    check({tag, " pc"}, 32'(bus.pc), 32'(e_pc));
    check({tag, " retired"}, 32'(bus.retired), e_ret);
  endtask

  initial begin
    logic [8:0]      ri;
    logic [PC_W-1:0] rt, e_pc;
    logic            rb;
    int              id, dd, e_rw, e_dm;

    tbl[0] = '{9'h001, 0, 0, 1'b0, 10'h000, 4, 1, 0, 10'h001, 1};
    tbl[1] = '{9'h080, 0, 3, 1'b0, 10'h000, 8, 1, 4, 10'h002, 2};
    tbl[2] = '{9'h0C0, 2, 0, 1'b0, 10'h000, 6, 0, 1, 10'h003, 3};
    tbl[3] = '{9'h100, 0, 0, 1'b1, 10'h005, 3, 0, 0, 10'h005, 4};
    tbl[4] = '{9'h100, 1, 0, 1'b1, 10'h020, 4, 0, 0, 10'h020, 5};
    tbl[5] = '{9'h101, 0, 0, 1'b1, 10'h005, 3, 0, 0, 10'h005, 6};
    tbl[6] = '{9'h100, 0, 0, 1'b0, 10'h3AA, 3, 0, 0, 10'h006, 7};
    tbl[7] = '{9'h183, 0, 0, 1'b0, 10'h000, 4, 1, 0, 10'h007, 8};
    tbl[8] = '{9'h100, 0, 0, 1'b1, 10'h3FF, 3, 0, 0, 10'h3FF, 9};
    tbl[9] = '{9'h005, 1, 0, 1'b0, 10'h000, 5, 1, 0, 10'h000, 10};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.instr      = '0;
    bus.imem_valid = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_target  = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset strobes", 32'({strobes(), bus.dmem_we, bus.done}), 0);
    check("reset pc", 32'(bus.pc), 0);
    check("reset ir", 32'(bus.ir), 0);
    check("reset retired", 32'(bus.retired), 0);
    rst_n = 1'b1;

    // IDLE ignores instruction memory until start
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.imem_valid = 1'b1;
      bus.instr      = 9'h001;
      bus.dmem_ready = 1'b1;
      #1;
      check("idle strobes", 32'({strobes(), bus.done}), 0);
    end
    @(negedge clk);
    check("idle pc", 32'(bus.pc), 0);
    bus.start      = 1'b1;
    bus.imem_valid = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_insn($sformatf("tbl%0d", v), tbl[v].instr, tbl[v].idly, tbl[v].ddly, tbl[v].bt,
               tbl[v].tgt, tbl[v].lat, tbl[v].rw, tbl[v].dm, tbl[v].pc, tbl[v].ret);
    end
    m_pc  = 10'h000;
    m_ret = 10;

    for (int v = 0; v < N_RAND; v++) begin
      ri = 9'($urandom_range(0, 511));
      if (ri == 9'h1FF) ri = 9'h1FE;
      id = $urandom_range(0, 3);
      dd = $urandom_range(0, 4);
      rb = 1'($urandom_range(0, 1));
      rt = ($urandom_range(0, 3) == 0) ? 10'h3FF : PC_W'($urandom_range(0, 1023));
      e_rw  = ((ri[8:7] == 2'b10) || (ri[8:7] == 2'b01 && ri[6])) ? 0 : 1;
      e_dm  = (ri[8:7] == 2'b01) ? dd + 1 : 0;
      e_pc  = (ri[8:7] == 2'b10 && rb) ? rt : m_pc + 1'b1;
      m_ret = (m_ret < RET_MAX) ? m_ret + 1 : RET_MAX;
      run_insn($sformatf("rnd%0d", v), ri, id, dd, rb, rt, model_lat(ri, id, dd),
               e_rw, e_dm, e_pc, m_ret);
      m_pc = e_pc;
    end

    // HALT: nothing retires, done held, then start restarts from RESET_PC
    @(negedge clk);
    bus.start      = 1'b0;
    bus.imem_valid = 1'b1;
    bus.instr      = 9'h1FF;
    #1;
    check("halt ir_load", 32'(bus.ir_load), 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.instr = 9'h001;
    #1;
    check("halt decode strobes", 32'({strobes(), bus.done}), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.start      = 1'b0;
      bus.dmem_ready = 1'b1;
      #1;
      check("halt done", 32'(bus.done), 1);
      check("halt strobes", 32'(strobes()), 0);
      check("halt pc", 32'(bus.pc), 32'(m_pc));
      check("halt retired", 32'(bus.retired), m_ret);
    end
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    check("halt done before restart", 32'(bus.done), 1);
    @(posedge clk);
    #1;
    check("restart pc", 32'(bus.pc), 0);
    check("restart retired", 32'(bus.retired), 0);
    check("restart done", 32'(bus.done), 0);
    run_insn("post_restart", 9'h002, 0, 0, 1'b0, 10'h000, 4, 1, 0, 10'h001, 1);

    // Async reset while a load waits in MEM
    @(negedge clk);
    bus.start      = 1'b0;
    bus.instr      = 9'h080;
    bus.imem_valid = 1'b1;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mem dmem_req before reset", 32'(bus.dmem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset in mem dmem_req", 32'(bus.dmem_req), 0);
    check("reset in mem pc", 32'(bus.pc), 0);
    check("reset in mem retired", 32'(bus.retired), 0);
    check("reset in mem ir", 32'(bus.ir), 0);
    @(negedge clk);
    bus.imem_valid = 1'b1;
    bus.dmem_ready = 1'b1;
    #1;
    check("reset held strobes", 32'({strobes(), bus.done}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("after reset idle strobes", 32'({strobes(), bus.done}), 0);
    check("after reset pc", 32'(bus.pc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
